periph_handshake_rx: RTL and testbench
======================================

PERIPH_HANDSHAKE_RX -- requirements
Module: periph_handshake_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 2: width of the handshake data word.
REQ-002 SHALL have parameter DEPTH, default 4: receive FIFO depth in words; a power of two, at least 2.
REQ-003 SHALL have port clk1, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst1, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port send, input, 1: producer request; high means dataInput is valid and stable.
REQ-006 SHALL have port dataInput, input, DATA_W: producer data word.
REQ-007 SHALL have port ack, output, 1: handshake acknowledge, registered.
REQ-008 SHALL have port rd_en, input, 1: consumer pop request.
REQ-009 SHALL have port rd_data, output, DATA_W: head-of-FIFO word, first-word-fall-through.
REQ-010 SHALL have port empty, output, 1: FIFO holds 0 words.
REQ-011 SHALL have port full, output, 1: FIFO holds DEPTH words.
REQ-012 SHALL have port count, output, clog2(DEPTH)+1: number of words held.

Function
REQ-013 SHALL implement a four-phase handshake FSM with states IDLE, ACK and WAIT_LOW.
REQ-014 IDLE: send_s (sampled send, see REQ-024) high and full low SHALL write dataInput at the tail, set ack=1 and go to ACK, all on the same edge.
REQ-015 IDLE: send_s high and full high SHALL stall: no write, ack stays 0, state stays IDLE until a pop frees a slot.
REQ-016 ACK: SHALL hold ack=1 and go to WAIT_LOW on the next edge.
REQ-017 WAIT_LOW: SHALL hold ack=1 while send_s is high; when send_s is low, SHALL clear ack and return to IDLE on that edge.
REQ-018 Exactly one word SHALL be written per handshake, however long send stays high.
REQ-019 A pop (rd_en high, empty low) SHALL advance the head pointer; rd_en while empty SHALL be ignored with no state change.
REQ-020 A write and a pop on the same edge SHALL leave count unchanged; a pop on a full FIFO SHALL allow a stalled write on the following edge.
REQ-021 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL be exact over 0..DEPTH.
REQ-022 rd_data SHALL equal the head word when empty is low, and 0 when empty is high.
REQ-023 empty, full and count SHALL be registered and consistent with each other on every cycle.

Reset
REQ-024 While rst1 is high at an edge: state SHALL be IDLE, ack=0, pointers=0, count=0, empty=1, full=0, rd_data=0, and any synchroniser flops SHALL be 0.
REQ-025 Reset mid-handshake SHALL abort it; a producer still holding send high after reset release SHALL be treated as a new request.
REQ-026 FIFO storage contents need not be reset.

Configuration
REQ-027 With macro PERIPH_RX_SYNC_EN defined, send SHALL pass through a two-flop synchroniser before the FSM, so send_s lags send by 2 cycles; dataInput SHALL be captured unsynchronised, which the protocol guarantees is stable while send is high.
REQ-028 Without PERIPH_RX_SYNC_EN, send_s SHALL equal send, with no added latency.

Verification (DATA_W=2, DEPTH=4, macro undefined unless stated)
REQ-029 Release rst1, then send=1 with dataInput=2'b11 at edge N -> ack=1 after N, count=1, rd_data=2'b11; drop send at N+3 -> ack=0 after edge N+3.
REQ-030 Five handshakes with data 0,1,2,3,0 and no pops -> full=1 after the fourth; the fifth gets no ack; one pop -> fifth acked next cycle; pops return 1,2,3,0.
REQ-031 Count=2, then a handshake write and rd_en on the same edge -> count stays 2 and order is preserved.
REQ-032 rd_en on an empty FIFO for 3 cycles -> count=0, empty=1, rd_data=0, no pointer movement.
REQ-033 Assert rst1 one cycle while in WAIT_LOW with count=3 -> ack=0, count=0, empty=1 after the edge.
REQ-034 Macro PERIPH_RX_SYNC_EN defined, send rises before edge N -> ack first high after edge N+2, falls 2 edges after the edge send is first sampled low.

Source files
------------

// File: rtl/periph_handshake_rx.sv
// Four-phase handshake receiver into a first-word-fall-through FIFO; ack is registered, a write lands on the edge ack rises.
// Stalls (ack held low) while full. Optional macro PERIPH_RX_SYNC_EN adds a two-flop synchroniser on send (2-cycle lag).
module periph_handshake_rx #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk1,
    input  logic                     rst1,
    input  logic                     send,
    input  logic [DATA_W-1:0]        dataInput,
    output logic                     ack,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

    logic [1:0]        r_state;
    logic              r_ack;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_empty;
    logic              r_full;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_send_s;
    logic              w_wr;
    logic              w_pop;
    logic [CW-1:0]     w_cnt_nxt;

`ifdef PERIPH_RX_SYNC_EN
    logic r_send_m;
    logic r_send_s;

    always_ff @(posedge clk1) begin
        if (rst1) begin
            r_send_m <= 1'b0;
            r_send_s <= 1'b0;
        end else begin
            r_send_m <= send;
            r_send_s <= r_send_m;
        end
    end

    assign w_send_s = r_send_s;
`else
    assign w_send_s = send;
`endif

    // Full is the registered flag, so a pop on a full FIFO frees the slot for the next edge, not this one.
    assign w_wr  = (r_state == ST_IDLE) && w_send_s && !r_full;
    assign w_pop = rd_en && !r_empty;

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_cnt_nxt = r_count + 1'b1;
            2'b01:   w_cnt_nxt = r_count - 1'b1;
            default: w_cnt_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_send_s && !r_full) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_WAIT_LOW;
                    r_ack   <= 1'b1;
                end
                ST_WAIT_LOW: begin
                    if (!w_send_s) begin
                        r_state <= ST_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk1) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= dataInput;
    end

    assign ack     = r_ack;
    assign rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty   = r_empty;
    assign full    = r_full;
    assign count   = r_count;

endmodule

// File: tb/tb_periph_handshake_rx.sv
// Scoreboard bench for periph_handshake_rx (DATA_W=2, DEPTH=4); expected words are queued as handshakes are driven.
// Inputs change and outputs are sampled on the falling edge; synchroniser lag follows PERIPH_RX_SYNC_EN.
module tb_periph_handshake_rx;

`ifdef PERIPH_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk1 = 1'b0;
    logic       rst1;
    logic       send;
    logic [1:0] dataInput;
    logic       ack;
    logic       rd_en;
    logic [1:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    periph_handshake_rx #(.DATA_W(2), .DEPTH(4)) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .send      (send),
        .dataInput (dataInput),
        .ack       (ack),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (ack !== lvl && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ack !== lvl) begin
            failures++;
            $display("FAIL %s ack timeout got=%b exp=%b", name, ack, lvl);
        end
    endtask

    task automatic hs_push(input logic [1:0] d);
        send = 1'b1;
        dataInput = d;
        wait_ack(1'b1, "hs_rise");
        exp_q.push_back(d);
        send = 1'b0;
        wait_ack(1'b0, "hs_fall");
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            checks++;
            if (rd_data !== exp_q[0]) begin
                failures++;
                $display("FAIL %s rd_data got=%0d exp=%0d", name, rd_data, exp_q[0]);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            void'(exp_q.pop_front());
            n++;
        end
        checks++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            failures++;
            $display("FAIL %s drained empty=%b count=%0d exp empty=1 count=0", name, empty, count);
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; send = 1'b0; rd_en = 1'b0; dataInput = 2'd0;
        tick();
        tick();
        checks++;
        if (ack !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 2'd0) begin
            failures++;
            $display("FAIL reset ack=%b count=%0d empty=%b full=%b rd_data=%0d exp 0/0/1/0/0",
                     ack, count, empty, full, rd_data);
        end
        rst1 = 1'b0;
        tick();
    endtask

    task automatic test_single();
        send = 1'b1;
        dataInput = 2'b11;
        for (int i = 0; i <= SYNC_LAT; i++) begin
            tick();
            checks++;
            if (ack !== (i == SYNC_LAT)) begin
                failures++;
                $display("FAIL single_ack_latency edge=%0d got=%b exp=%b", i, ack, (i == SYNC_LAT));
            end
        end
        exp_q.push_back(2'b11);
        checks++;
        if (count !== 3'd1 || rd_data !== 2'b11 || empty !== 1'b0) begin
            failures++;
            $display("FAIL single_write count=%0d rd_data=%0d empty=%b exp 1/3/0", count, rd_data, empty);
        end
        tick();
        tick();
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL single_ack_hold got=%b exp=1", ack);
        end
        send = 1'b0;
        for (int i = 0; i <= SYNC_LAT; i++) begin
            tick();
            checks++;
            if (ack !== (i != SYNC_LAT)) begin
                failures++;
                $display("FAIL single_ack_fall edge=%0d got=%b exp=%b", i, ack, (i != SYNC_LAT));
            end
        end
        checks++;
        if (count !== 3'd1) begin
            failures++;
            $display("FAIL single_one_word count=%0d exp=1", count);
        end
        drain("single_drain");
    endtask

    task automatic test_full_stall();
        hs_push(2'd0);
        hs_push(2'd1);
        hs_push(2'd2);
        hs_push(2'd3);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
            failures++;
            $display("FAIL full_flag full=%b count=%0d empty=%b exp 1/4/0", full, count, empty);
        end
        send = 1'b1;
        dataInput = 2'd0;
        repeat (SYNC_LAT + 4) tick();
        checks++;
        if (ack !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL full_stall ack=%b count=%0d exp ack=0 count=4", ack, count);
        end
        checks++;
        if (rd_data !== exp_q[0]) begin
            failures++;
            $display("FAIL full_head rd_data=%0d exp=%0d", rd_data, exp_q[0]);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (ack !== 1'b0 || count !== 3'd3 || full !== 1'b0) begin
            failures++;
            $display("FAIL full_pop ack=%b count=%0d full=%b exp 0/3/0", ack, count, full);
        end
        tick();
        checks++;
        if (ack !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL full_resume ack=%b count=%0d exp ack=1 count=4", ack, count);
        end
        exp_q.push_back(2'd0);
        send = 1'b0;
        wait_ack(1'b0, "full_fall");
        drain("full_drain");
    endtask

    task automatic test_simul();
        hs_push(2'd1);
        hs_push(2'd2);
        send = 1'b1;
        dataInput = 2'd3;
        repeat (SYNC_LAT) tick();
        checks++;
        if (rd_data !== exp_q[0] || count !== 3'd2) begin
            failures++;
            $display("FAIL simul_pre rd_data=%0d count=%0d exp %0d/2", rd_data, count, exp_q[0]);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(2'd3);
        checks++;
        if (ack !== 1'b1 || count !== 3'd2) begin
            failures++;
            $display("FAIL simul_count ack=%b count=%0d exp ack=1 count=2", ack, count);
        end
        send = 1'b0;
        wait_ack(1'b0, "simul_fall");
        drain("simul_drain");
    endtask

    task automatic test_empty_pop();
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || rd_data !== 2'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL empty_pop count=%0d empty=%b rd_data=%0d full=%b exp 0/1/0/0",
                     count, empty, rd_data, full);
        end
        hs_push(2'd2);
        checks++;
        if (rd_data !== 2'd2 || count !== 3'd1) begin
            failures++;
            $display("FAIL empty_pop_ptr rd_data=%0d count=%0d exp 2/1", rd_data, count);
        end
        drain("empty_drain");
    endtask

    task automatic test_reset_mid();
        hs_push(2'd1);
        hs_push(2'd2);
        send = 1'b1;
        dataInput = 2'd3;
        wait_ack(1'b1, "mid_rise");
        tick();
        tick();
        checks++;
        if (ack !== 1'b1 || count !== 3'd3) begin
            failures++;
            $display("FAIL mid_pre ack=%b count=%0d exp ack=1 count=3", ack, count);
        end
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        exp_q.delete();
        checks++;
        if (ack !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset ack=%b count=%0d empty=%b full=%b exp 0/0/1/0", ack, count, empty, full);
        end
        wait_ack(1'b1, "mid_rerequest");
        exp_q.push_back(2'd3);
        checks++;
        if (count !== 3'd1 || rd_data !== 2'd3) begin
            failures++;
            $display("FAIL mid_new count=%0d rd_data=%0d exp 1/3", count, rd_data);
        end
        send = 1'b0;
        wait_ack(1'b0, "mid_fall");
        drain("mid_drain");
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_stall();
        test_simul();
        test_empty_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
